// File: rtl/uart_rx_fifo_if.sv
// Bundled serial-line, frame-format and FIFO read-side signals of uart_rx_fifo.
// master drives the line, format and pop strobe; slave is the receiver.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 8,
  parameter int K_W        = 19
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic           Rx;
  logic           eight;
  logic           pen;
  logic           even;
  logic [K_W-1:0] k;
  logic           reads0;
  logic           RxRdy;
  logic [7:0]     data;
  logic           perr;
  logic           ferr;
  logic           ovf;
  logic [CW-1:0]  count;

  modport master (
    output Rx, eight, pen, even, k, reads0,
    input  RxRdy, data, perr, ferr, ovf, count
  );

  modport slave (
    input  Rx, eight, pen, even, k, reads0,
    output RxRdy, data, perr, ferr, ovf, count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (7/8 data bits, optional parity) feeding a first-word-fall-through FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int K_W        = 19
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } entry_t;

  // ---------------- control state ----------------
  logic           sync1_q, sync2_q, prev_q;
  state_t         state_q, state_d;
  logic [K_W-1:0] cnt_q, cnt_d;
  logic [3:0]     idx_q, idx_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;
  logic           rdy_q, rdy_d;
  entry_t         head_q, head_d;

  // ---------------- frame datapath ----------------
  logic [K_W-1:0] k_q, k_d;
  logic           eight_q, eight_d, pen_q, pen_d, even_q, even_d;
  logic [8:0]     sh_q, sh_d;
  entry_t         mem_q [FIFO_DEPTH];

  logic           rx_s, fall, evt, smp, push;
  logic [3:0]     last_idx;
  logic [7:0]     data_bits;
  logic           par_bit;
  entry_t         new_e;
  logic           full, pop, wr_en;

  assign rx_s = sync2_q;
  assign fall = prev_q & ~sync2_q;

`ifdef UART_RX_MAJORITY_EN
  logic samp_m1_q, samp_m1_d, samp_0_q, samp_0_d, pend_q, pend_d;

  // Samples at terminal-1 and terminal are held; the decision is taken one
  // cycle later together with the terminal+1 sample.
  always_comb begin
    samp_m1_d = (cnt_q == K_W'(1)) ? rx_s : samp_m1_q;
    samp_0_d  = (cnt_q == '0) ? rx_s : samp_0_q;
    pend_d    = (state_q != IDLE) && (cnt_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= pend_d;
  end

  always_ff @(posedge clk) begin
    samp_m1_q <= samp_m1_d;
    samp_0_q  <= samp_0_d;
  end

  assign evt = pend_q;
  assign smp = (samp_m1_q & samp_0_q) | (samp_m1_q & rx_s) | (samp_0_q & rx_s);
`else
  assign evt = (state_q != IDLE) && (cnt_q == '0);
  assign smp = rx_s;
`endif

  // ---------------- receive FSM ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    k_d     = k_q;
    eight_d = eight_q;
    pen_d   = pen_q;
    even_d  = even_q;
    push    = 1'b0;

    // Down-counter free-runs through a frame, reloading for one bit time.
    if (state_q != IDLE) begin
      cnt_d = (cnt_q == '0) ? (k_q - 1'b1) : (cnt_q - 1'b1);
    end

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = bus.k >> 1;
          k_d     = bus.k;
          eight_d = bus.eight;
          pen_d   = bus.pen;
          even_d  = bus.even;
          idx_d   = '0;
          sh_d    = '0;
        end
      end
      START: begin
        if (evt) state_d = smp ? IDLE : SHIFT;
      end
      SHIFT: begin
        if (evt) begin
          sh_d[idx_q] = smp;
          idx_d       = idx_q + 1'b1;
          if (idx_q == last_idx) state_d = STOP;
        end
      end
      STOP: begin
        if (evt) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_idx  = (eight_q ? 4'd8 : 4'd7) + {3'b000, pen_q} - 4'd1;
    data_bits = eight_q ? sh_q[7:0] : {1'b0, sh_q[6:0]};
    par_bit   = eight_q ? sh_q[8] : sh_q[7];
    new_e.data = data_bits;
    // Error when data+parity ones count disagrees with the selected parity.
    new_e.perr = pen_q & (^data_bits ^ par_bit ^ ~even_q);
    new_e.ferr = ~smp;
  end

  // ---------------- FIFO control ----------------
  always_comb begin
    full  = (count_q == FULL);
    pop   = bus.reads0 && (count_q != '0);
    wr_en = push && (!full || pop);

    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (!wr_en && pop) count_d = count_q - 1'b1;

    // A full-FIFO push that coincides with a pop leaves the flag alone.
    ovf_d = ovf_q;
    if (push && full && !pop)       ovf_d = 1'b1;
    else if (pop && !(push && full)) ovf_d = 1'b0;

    rdy_d = (count_d != '0);

    // Head output register looks ahead so it is valid together with RxRdy.
    if (count_d == '0)                      head_d = '0;
    else if (wr_en && (wr_ptr_q == rd_ptr_d)) head_d = new_e;
    else                                     head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rdy_q    <= 1'b0;
      head_q   <= '0;
    end else begin
      sync1_q  <= bus.Rx;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rdy_q    <= rdy_d;
      head_q   <= head_d;
    end
  end

  // ---------------- datapath registers (no reset) ----------------
  always_ff @(posedge clk) begin
    k_q     <= k_d;
    eight_q <= eight_d;
    pen_q   <= pen_d;
    even_q  <= even_d;
    sh_q    <= sh_d;
    if (wr_en) mem_q[wr_ptr_q] <= new_e;
  end

  assign bus.RxRdy = rdy_q;
  assign bus.data  = head_q.data;
  assign bus.perr  = head_q.perr;
  assign bus.ferr  = head_q.ferr;
  assign bus.ovf   = ovf_q;
  assign bus.count = count_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames against a queue model of the received entries.
module tb_uart_rx_fifo;
  localparam int DEPTH = 4;
  localparam int K_W   = 19;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH), .K_W(K_W)) bus();

  uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .K_W(K_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t mq[$];
  bit   m_ovf   = 1'b0;
  bit   chk_en  = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: a received frame is either appended or, when DEPTH entries are held, dropped with ovf.
  task automatic model_push(input ent_t e);
    if (mq.size() == DEPTH) m_ovf = 1'b1;
    else mq.push_back(e);
  endtask

  task automatic drive(input logic v, input int n);
    bus.Rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    ent_t t;
    bus.reads0 = 1'b1;
    @(posedge clk);
    #1;
    bus.reads0 = 1'b0;
    if (mq.size() > 0) begin
      t = mq.pop_front();
      m_ovf = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit e8, input bit p, input bit ev,
                            input int kk, input bit bad_par, input bit stop_bit,
                            input bit scramble, input int gap);
    logic [7:0] db;
    logic       par;
    ent_t       e;
    bus.eight = e8;
    bus.pen   = p;
    bus.even  = ev;
    bus.k     = K_W'(kk);
    db  = e8 ? b : {1'b0, b[6:0]};
    par = ev ? ^db : ~^db;
    if (bad_par) par = ~par;
    drive(1'b0, kk);
    if (scramble) begin
      bus.eight = 1'($urandom);
      bus.pen   = 1'($urandom);
      bus.even  = 1'($urandom);
      bus.k     = K_W'($urandom_range(16, 200));
    end
    for (int i = 0; i < (e8 ? 8 : 7); i++) drive(b[i], kk);
    if (p) drive(par, kk);
    // The push lands somewhere inside the stop bit; outputs are not compared there.
    chk_en = 1'b0;
    drive(stop_bit, kk);
    e.d  = db;
    e.pe = p & bad_par;
    e.fe = ~stop_bit;
    model_push(e);
    chk_en = 1'b1;
    drive(1'b1, 4 + gap);
  endtask

  always @(negedge clk) begin
    logic [15:0] act, exp;
    if (chk_en) begin
      act = {bus.RxRdy, bus.ovf, 4'(bus.count), bus.data, bus.perr, bus.ferr};
      exp = {mq.size() != 0, m_ovf, 4'(mq.size()), 10'h000};
      if (mq.size() != 0) exp[9:0] = {mq[0].d, mq[0].pe, mq[0].fe};
      else act[9:0] = 10'h000;
      check("cycle", 32'(act), 32'(exp));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    bus.Rx = 1'b1; bus.eight = 1'b1; bus.pen = 1'b0; bus.even = 1'b0;
    bus.k = K_W'(109); bus.reads0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy",   32'(bus.RxRdy), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_data",  32'(bus.data),  0);
    check("rst_ovf",   32'(bus.ovf),   0);
    rst = 1'b0;
    chk_en = 1'b1;
    drive(1'b1, 10);

    // 0xA5 8N1 at k=109
    send_frame(8'hA5, 1, 0, 0, 109, 0, 1, 0, 5);
    check("a5_model", 32'(mq[0].d), 32'h A5);
    check("a5_rdy",   32'(bus.RxRdy), 1);
    check("a5_data",  32'(bus.data),  32'hA5);
    check("a5_perr",  32'(bus.perr),  0);
    check("a5_ferr",  32'(bus.ferr),  0);
    check("a5_count", 32'(bus.count), 1);
    pop_one();

    // 0x5A even parity: wrong parity bit (1) then correct one (0)
    send_frame(8'h5A, 1, 1, 1, 32, 1, 1, 0, 5);
    send_frame(8'h5A, 1, 1, 1, 32, 0, 1, 0, 5);
    check("par_model", 32'(mq[0].pe), 1);
    check("par1_data", 32'(bus.data), 32'h5A);
    check("par1_perr", 32'(bus.perr), 1);
    pop_one();
    check("par0_data", 32'(bus.data), 32'h5A);
    check("par0_perr", 32'(bus.perr), 0);
    pop_one();

    // Framing error, then a normal frame proves return to idle
    send_frame(8'h3C, 1, 0, 0, 32, 0, 0, 0, 5);
    check("fe_data", 32'(bus.data), 32'h3C);
    check("fe_ferr", 32'(bus.ferr), 1);
    pop_one();
    send_frame(8'h55, 1, 0, 0, 32, 0, 1, 0, 5);
    check("fe_next", 32'(bus.data), 32'h55);
    pop_one();

    // Start glitch of 20 clocks is rejected
    bus.k = K_W'(109);
    drive(1'b0, 20);
    drive(1'b1, 300);
    check("glitch_rdy",   32'(bus.RxRdy), 0);
    check("glitch_count", 32'(bus.count), 0);
    send_frame(8'h96, 1, 0, 0, 109, 0, 1, 0, 5);
    check("glitch_next", 32'(bus.data), 32'h96);
    pop_one();

    // Five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, 0, 0, 20, 0, 1, 0, 0);
    check("ovf_count", 32'(bus.count), 4);
    check("ovf_set",   32'(bus.ovf),   1);
    check("ovf_head",  32'(bus.data),  1);
    pop_one();
    check("ovf_clr",   32'(bus.ovf),   0);
    for (int i = 2; i <= 4; i++) begin
      check("ovf_pop", 32'(bus.data), 32'(i));
      pop_one();
    end
    check("ovf_empty", 32'(bus.RxRdy), 0);
    pop_one();

    // Reset in the middle of the 4th data bit
    send_frame(8'hC3, 1, 0, 0, 32, 0, 1, 0, 5);
    bus.eight = 1'b1; bus.pen = 1'b0; bus.k = K_W'(32);
    drive(1'b0, 32);
    drive(1'b1, 32); drive(1'b0, 32); drive(1'b1, 32);
    drive(1'b0, 12);
    rst = 1'b1;
    bus.Rx = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mrst_rdy",   32'(bus.RxRdy), 0);
    check("mrst_data",  32'(bus.data),  0);
    check("mrst_perr",  32'(bus.perr),  0);
    check("mrst_ferr",  32'(bus.ferr),  0);
    check("mrst_ovf",   32'(bus.ovf),   0);
    check("mrst_count", 32'(bus.count), 0);
    rst = 1'b0;
    drive(1'b1, 20);
    send_frame(8'h81, 0, 0, 0, 32, 0, 1, 0, 5);
    check("mrst_7n1", 32'(bus.data), 32'h01);
    pop_one();

    // Randomized frames with random pops between them
    for (int f = 0; f < 30; f++) begin
      logic [7:0] b;
      int         npop;
      b = 8'($urandom);
      send_frame(b, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(16, 48),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) != 0,
                 1'($urandom), $urandom_range(0, 12));
      npop = $urandom_range(0, 3);
      for (int j = 0; j < npop; j++) pop_one();
    end
    for (int j = 0; j < DEPTH + 1; j++) pop_one();
    check("final_empty", 32'(bus.count), 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
